countdown_tick_ctrl: RTL and testbench
======================================

// Module: countdown_tick_ctrl
// PURPOSE
//  Initiator end of the digit-timer borrow chain. Generates the clock-synchronous borrow pulses
//  that drive the least-significant digit, issues the load pulse that makes the digits reload
//  their default values, and watches the chain's no-borrow flag to detect 00 (timeout).
//  Sits between the board clock/pushbutton logic and the cascaded digit timers.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per timer tick (one borrow pulse per tick); must be >= 8
//  TICK_W     26          prescaler width; must satisfy 2**TICK_W > TICK_DIV-1
//  PULSE_CYC  1           width of each borrow_req pulse, in clk cycles (1..4)
//  LOAD_CYC   2           width of the load_digits pulse, in clk cycles (1..4)
// PORTS
//  clk          in   1  system clock; all state changes on its rising edge
//  rst          in   1  asynchronous, active-low reset
//  start        in   1  1-cycle request to start or resume counting
//  stop         in   1  1-cycle request to pause counting
//  reload       in   1  1-cycle request to reload digit defaults and return to idle
//  chain_zero   in   1  no-borrow output of digit 0; 1 = whole chain reads zero; asynchronous to clk
//  borrow_req   out  1  borrow pulse to digit 0 (digit decrements once per pulse)
//  load_digits  out  1  active-high load/reset pulse to every digit in the chain
//  running      out  1  1 while in RUN
//  paused       out  1  1 while in PAUSE
//  timeout      out  1  1 while in EXPIRED (sticky until reload or reset)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, prescaler=0, sync flops=0, every output 0.
//  - chain_zero passes through a 2-flop synchronizer -> cz_s. Only cz_s is used internally.
//  - Input priority when requests coincide: reload > stop > start.
//  - States:
//    - IDLE
//      - reload -> LOAD.
//      - start with cz_s=0 -> RUN.
//      - start with cz_s=1 -> EXPIRED.
//    - LOAD
//      - load_digits=1 for exactly LOAD_CYC cycles, prescaler cleared, then -> IDLE.
//      - A reload arriving during LOAD restarts the LOAD_CYC count.
//    - RUN
//      - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
//      - On the cycle after the prescaler reads TICK_DIV-1, and only if cz_s=0, borrow_req goes
//        high for PULSE_CYC cycles.
//      - borrow_req is driven from a flop: glitch-free, never wider than PULSE_CYC.
//      - cz_s=1 -> EXPIRED on the next edge; no further borrow_req is issued.
//      - stop -> PAUSE.
//      - reload -> LOAD.
//    - PAUSE
//      - Prescaler holds its value; no borrow_req.
//      - start -> RUN, resuming from the held prescaler value.
//      - stop is ignored.
//      - reload -> LOAD.
//    - EXPIRED
//      - timeout=1.
//      - start and stop are ignored.
//      - reload -> LOAD.
//  - Timing
//    - running rises 1 cycle after start is sampled.
//    - The first borrow_req rises TICK_DIV+1 cycles after the start edge.
//    - timeout rises 3 cycles after chain_zero rises (2 sync + 1 state) while in RUN.
//  - Boundaries
//    - An in-flight borrow pulse completes its full PULSE_CYC width on stop, but is cut
//      immediately on reload or reset.
//    - reset mid-count discards the prescaler.
//    - Prescaler wrap is exact modulo TICK_DIV; no drift across ticks.
// STRUCTURE
//  - Shared header timer_defs.vh holds:
//    - state encodings ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE, ST_EXPIRED (3-bit);
//    - default TICK_DIV and TICK_W.
//  - One sub-module, tick_prescaler: modulo-TICK_DIV counter with enable and clear inputs and a
//    1-cycle wrap strobe.
//  - FSM, synchronizer and pulse stretchers live in the top level.
// TESTING
//  Bench uses TICK_DIV=8, PULSE_CYC=1, LOAD_CYC=2 and a behavioural 2-digit chain model loaded
//  with 03.
//  1. reset, then reload -> load_digits high for exactly 2 cycles, state IDLE, all other
//     outputs 0.
//  2. start -> running at +1 cycle; borrow_req 1-cycle pulses at +9, +17, +25 cycles;
//     after 3 pulses chain_zero=1, timeout=1 3 cycles later; no 4th pulse.
//  3. stop 3 cycles after a tick, hold 20 cycles, start -> no borrow_req while paused;
//     the next pulse arrives 5 cycles after resume.
//  4. start, stop and reload asserted on the same cycle during RUN -> LOAD wins;
//     load_digits pulses; running=0.
//  5. start with the chain already at 00 -> timeout=1 with zero borrow_req pulses;
//     a further start is ignored; reload clears timeout.
//  6. rst low mid-pulse and mid-count -> all outputs 0 immediately (async);
//     after release, the first tick again needs a full TICK_DIV after start.

Source files
------------

// File: rtl/countdown_tick_ctrl_pkg.sv
// Shared definitions for the digit-timer tick controller: state encoding and
// default prescaler sizing for a 50 MHz board clock with a 1 s tick.
package countdown_tick_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  localparam int unsigned DEF_TICK_DIV = 50_000_000;
  localparam int unsigned DEF_TICK_W   = 26;

endpackage

// File: rtl/countdown_tick_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV counter. wrap_o is high on the enabled cycle where the count
// reads TICK_DIV-1, i.e. the edge on which it returns to zero.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned TICK_W   = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_tick_ctrl.sv
// Initiator of the digit-timer borrow chain: paces borrow pulses to digit 0,
// issues the digit load pulse and detects the all-zero (timeout) condition.
module countdown_tick_ctrl
  import countdown_tick_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned TICK_W    = DEF_TICK_W,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned LOAD_CYC  = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   stop,
  input  logic   reload,
  input  logic   chain_zero,
  output logic   borrow_req,
  output logic   load_digits,
  output logic   running,
  output logic   paused,
  output logic   timeout,
  output state_t state_dbg
);

  localparam logic [1:0] PULSE_LAST = 2'(PULSE_CYC - 1);
  localparam logic [1:0] LOAD_LAST  = 2'(LOAD_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] load_cnt_q, load_cnt_d;
  logic       borrow_q, borrow_d;
  logic [1:0] pulse_cnt_q, pulse_cnt_d;
  logic       cz_meta_q, cz_s_q;
  logic       tick_wrap;

  // chain_zero comes from the ripple chain with no clock relationship.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cz_meta_q <= 1'b0;
      cz_s_q    <= 1'b0;
    end else begin
      cz_meta_q <= chain_zero;
      cz_s_q    <= cz_meta_q;
    end
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (state_q == ST_RUN),
    .clr_i  (state_q == ST_LOAD),
    .wrap_o (tick_wrap)
  );

  // Priority reload > stop > start; a reload inside LOAD restarts its width.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
        end else if (start) begin
          state_d = cz_s_q ? ST_EXPIRED : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (reload) begin
          load_cnt_d = LOAD_LAST;
        end else if (load_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          load_cnt_d = load_cnt_q - 2'd1;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (cz_s_q) begin
          state_d = ST_EXPIRED;
        end
      end
      ST_PAUSE: begin
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = LOAD_LAST;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        load_cnt_d = 2'd0;
      end
    endcase
  end

  // A started pulse runs its full width unless reload cuts it.
  always_comb begin
    borrow_d    = borrow_q;
    pulse_cnt_d = pulse_cnt_q;
    if (reload) begin
      borrow_d    = 1'b0;
      pulse_cnt_d = 2'd0;
    end else if (tick_wrap && !cz_s_q) begin
      borrow_d    = 1'b1;
      pulse_cnt_d = PULSE_LAST;
    end else if (borrow_q) begin
      if (pulse_cnt_q == 2'd0) begin
        borrow_d = 1'b0;
      end else begin
        pulse_cnt_d = pulse_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= 2'd0;
      borrow_q    <= 1'b0;
      pulse_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      borrow_q    <= borrow_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign borrow_req  = borrow_q;
  assign load_digits = (state_q == ST_LOAD);
  assign running     = (state_q == ST_RUN);
  assign paused      = (state_q == ST_PAUSE);
  assign timeout     = (state_q == ST_EXPIRED);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_countdown_tick_ctrl.sv
// Bench for countdown_tick_ctrl: directed scenarios plus random requests,
// checked cycle by cycle against a behavioural controller + 2-digit chain model.
module tb_countdown_tick_ctrl;
  import countdown_tick_ctrl_pkg::*;

  localparam int TICK_DIV  = 8;
  localparam int PULSE_CYC = 1;
  localparam int LOAD_CYC  = 2;
  localparam int W         = 8;

  logic   clk, rst, start, stop, reload, chain_zero;
  logic   borrow_req, load_digits, running, paused, timeout;
  state_t state_dbg;

  countdown_tick_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .TICK_W    (4),
    .PULSE_CYC (PULSE_CYC),
    .LOAD_CYC  (LOAD_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .reload      (reload),
    .chain_zero  (chain_zero),
    .borrow_req  (borrow_req),
    .load_digits (load_digits),
    .running     (running),
    .paused      (paused),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  string tag = "init";

  // behavioural model
  state_t m_mode;
  int     m_phase, m_pulse, m_load, m_chain, chain_dflt;
  logic   m_s1, m_s2;

  // observation history
  int cyc = 0;
  int borrow_cycles[$];
  int load_obs;
  int to_rise;
  logic to_prev = 1'b0;

  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode  = ST_IDLE;
    m_phase = 0;
    m_pulse = 0;
    m_load  = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  // One clock edge of the environment: digits react to the pre-edge outputs,
  // then the controller rules are applied to the pre-edge inputs.
  task automatic model_edge();
    logic czs, wrap;
    if (m_mode == ST_LOAD) m_chain = chain_dflt;
    else if (m_pulse > 0 && m_chain > 0) m_chain--;
    if (!rst) begin
      model_reset();
      return;
    end
    czs  = m_s2;
    m_s2 = m_s1;
    m_s1 = chain_zero;
    wrap = (m_mode == ST_RUN) && (m_phase % TICK_DIV == TICK_DIV - 1);
    if (reload) m_pulse = 0;
    else if (wrap && !czs) m_pulse = PULSE_CYC;
    else if (m_pulse > 0) m_pulse--;
    if (m_mode == ST_RUN) m_phase++;
    else if (m_mode == ST_LOAD) m_phase = 0;
    case (m_mode)
      ST_IDLE:    if (reload) begin m_mode = ST_LOAD; m_load = LOAD_CYC; end
                  else if (start) m_mode = czs ? ST_EXPIRED : ST_RUN;
      ST_LOAD:    if (reload) m_load = LOAD_CYC;
                  else if (m_load == 1) m_mode = ST_IDLE;
                  else m_load--;
      ST_RUN:     if (reload) begin m_mode = ST_LOAD; m_load = LOAD_CYC; end
                  else if (stop) m_mode = ST_PAUSE;
                  else if (czs) m_mode = ST_EXPIRED;
      ST_PAUSE:   if (reload) begin m_mode = ST_LOAD; m_load = LOAD_CYC; end
                  else if (start) m_mode = ST_RUN;
      default:    if (reload) begin m_mode = ST_LOAD; m_load = LOAD_CYC; end
    endcase
  endtask

  // scoreboard
  task automatic compare_outputs();
    logic [W-1:0] e;
    exp_q.push_back({m_mode, (m_pulse > 0), (m_mode == ST_LOAD), (m_mode == ST_RUN),
                     (m_mode == ST_PAUSE), (m_mode == ST_EXPIRED)});
    e = exp_q.pop_front();
    check_eq({tag, ".state"},   32'(state_dbg),   32'(e[7:5]));
    check_eq({tag, ".borrow"},  32'(borrow_req),  32'(e[4]));
    check_eq({tag, ".load"},    32'(load_digits), 32'(e[3]));
    check_eq({tag, ".running"}, 32'(running),     32'(e[2]));
    check_eq({tag, ".paused"},  32'(paused),      32'(e[1]));
    check_eq({tag, ".timeout"}, 32'(timeout),     32'(e[0]));
  endtask

  // driver tasks
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chain_zero = (m_chain == 0);
    compare_outputs();
    if (borrow_req) borrow_cycles.push_back(cyc);
    if (load_digits) load_obs++;
    if (timeout && !to_prev) to_rise = cyc;
    to_prev = timeout;
  endtask

  task automatic pulse_inputs(input logic s, input logic p, input logic r);
    start  = s;
    stop   = p;
    reload = r;
    step();
    start  = 1'b0;
    stop   = 1'b0;
    reload = 1'b0;
  endtask

  task automatic apply_reset_now();
    rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
  endtask

  task automatic wait_borrow(input int budget);
    int nb;
    nb = borrow_cycles.size();
    for (int k = 0; k < budget && borrow_cycles.size() == nb; k++) step();
    check_eq({tag, ".borrow_seen"}, 32'(borrow_cycles.size() > nb), 32'd1);
  endtask

  initial begin
    int c0, r, nb;
    rst = 1'b1; start = 1'b0; stop = 1'b0; reload = 1'b0;
    chain_dflt = 3; m_chain = 3; chain_zero = 1'b0;
    model_reset();
    #2;
    tag = "reset";
    apply_reset_now();
    repeat (3) step();
    rst = 1'b1;
    step();

    // 1: reload gives a LOAD_CYC-wide load pulse, back to IDLE
    tag = "t1";
    load_obs = 0;
    pulse_inputs(1'b0, 1'b0, 1'b1);
    repeat (4) step();
    check_eq("t1.load_width", 32'(load_obs), 32'(LOAD_CYC));
    check_eq("t1.idle", 32'(state_dbg), 32'(ST_IDLE));

    // 2: run from 03 to 00
    tag = "t2";
    borrow_cycles.delete();
    to_rise = -1;
    c0 = cyc;
    pulse_inputs(1'b1, 1'b0, 1'b0);
    check_eq("t2.running_at_1", 32'(running), 32'd1);
    repeat (45) step();
    check_eq("t2.n_pulses", 32'(borrow_cycles.size()), 32'd3);
    check_eq("t2.pulse1", 32'((borrow_cycles.size() > 0) ? borrow_cycles[0] - c0 : -1), 32'd9);
    check_eq("t2.pulse2", 32'((borrow_cycles.size() > 1) ? borrow_cycles[1] - c0 : -1), 32'd17);
    check_eq("t2.pulse3", 32'((borrow_cycles.size() > 2) ? borrow_cycles[2] - c0 : -1), 32'd25);
    check_eq("t2.timeout_rise", 32'(to_rise - c0), 32'd29);

    // 3: pause 3 cycles after a tick, resume
    tag = "t3";
    pulse_inputs(1'b0, 1'b0, 1'b1);
    repeat (3) step();
    pulse_inputs(1'b1, 1'b0, 1'b0);
    wait_borrow(20);
    repeat (2) step();
    pulse_inputs(1'b0, 1'b1, 1'b0);
    nb = borrow_cycles.size();
    repeat (20) step();
    check_eq("t3.no_pulse_paused", 32'(borrow_cycles.size()), 32'(nb));
    check_eq("t3.paused", 32'(paused), 32'd1);
    r = cyc + 1;
    pulse_inputs(1'b1, 1'b0, 1'b0);
    wait_borrow(20);
    check_eq("t3.resume_gap", 32'(borrow_cycles[borrow_cycles.size() - 1] - r), 32'd5);

    // 4: simultaneous start/stop/reload in RUN
    tag = "t4";
    pulse_inputs(1'b1, 1'b1, 1'b1);
    check_eq("t4.load_wins", 32'(state_dbg), 32'(ST_LOAD));
    check_eq("t4.running", 32'(running), 32'd0);
    repeat (3) step();

    // 5: start with chain already at 00
    tag = "t5";
    chain_dflt = 0;
    pulse_inputs(1'b0, 1'b0, 1'b1);
    repeat (4) step();
    borrow_cycles.delete();
    pulse_inputs(1'b1, 1'b0, 1'b0);
    check_eq("t5.timeout", 32'(timeout), 32'd1);
    pulse_inputs(1'b1, 1'b0, 1'b0);
    repeat (10) step();
    check_eq("t5.still_timeout", 32'(timeout), 32'd1);
    check_eq("t5.no_pulses", 32'(borrow_cycles.size()), 32'd0);
    chain_dflt = 3;
    pulse_inputs(1'b0, 1'b0, 1'b1);
    check_eq("t5.cleared", 32'(timeout), 32'd0);
    repeat (3) step();

    // 6: async reset mid-pulse and mid-count
    tag = "t6";
    pulse_inputs(1'b1, 1'b0, 1'b0);
    wait_borrow(20);
    apply_reset_now();
    check_eq("t6.borrow_cut", 32'(borrow_req), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    borrow_cycles.delete();
    c0 = cyc;
    pulse_inputs(1'b1, 1'b0, 1'b0);
    wait_borrow(20);
    check_eq("t6.first_tick", 32'((borrow_cycles.size() > 0) ? borrow_cycles[0] - c0 : -1), 32'd9);
    repeat (4) step();
    apply_reset_now();
    step();
    rst = 1'b1;
    borrow_cycles.delete();
    c0 = cyc;
    pulse_inputs(1'b1, 1'b0, 1'b0);
    wait_borrow(20);
    check_eq("t6.full_div", 32'((borrow_cycles.size() > 0) ? borrow_cycles[0] - c0 : -1), 32'd9);

    // random requests
    tag = "rand";
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 9) == 0);
      stop   = ($urandom_range(0, 19) == 0);
      reload = ($urandom_range(0, 39) == 0);
      if (reload) chain_dflt = $urandom_range(0, 6);
      if ($urandom_range(0, 249) == 0) begin
        apply_reset_now();
        step();
        rst = 1'b1;
      end
      step();
    end
    start = 1'b0; stop = 1'b0; reload = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
